load_unit: RTL and testbench

//  Read-side counterpart of the register-file store path. Takes one load from
//  EX (address, funct3, rd) and issues a 64-bit aligned read to data memory.
//  It then extracts and sign/zero-extends the addressed lanes and writes the

---
 rtl/load_unit.sv | 212 +++++++++++++++++++++
 tb/tb_load_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: accepts one load from EX, issues a doubleword-aligned read to
// data memory, extracts and extends the addressed lanes, and writes the
// result back through the register-file write port. One load in flight.
module load_unit #(
    parameter int CPU_WIDTH      = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // load request from EX
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [CPU_WIDTH-1:0]      ld_addr,
    input  logic [2:0]                ld_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    // data memory read interface
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [CPU_WIDTH-1:0]      mem_raddr,
    input  logic                      mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    // register file writeback
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [CPU_WIDTH-1:0]      reg_wdata,
    // retirement status
    output logic                      ld_done,
    output logic                      ld_err
);

    localparam int NUM_BYTES = CPU_WIDTH / 8;
    localparam int NUM_HALFS = CPU_WIDTH / 16;
    localparam int NUM_WORDS = CPU_WIDTH / 32;

    // funct3 encodings for loads; bit 2 selects zero extension
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                      state_reg;
    state_t                      state_next;

    logic [CPU_WIDTH-1:0]        addr_reg;
    logic [2:0]                  funct3_reg;
    logic [REG_ADDR_WIDTH-1:0]   rd_reg;
    logic [CPU_WIDTH-1:0]        data_reg;
    logic [7:0]                  timeout_cnt_reg;

    logic                        accept;
    logic                        bad_req;
    logic                        timeout_hit;
    logic [CPU_WIDTH-1:0]        ext_data;

    logic [7:0]                  byte_lane [NUM_BYTES];
    logic [15:0]                 half_lane [NUM_HALFS];
    logic [31:0]                 word_lane [NUM_WORDS];
    logic [7:0]                  byte_sel;
    logic [15:0]                 half_sel;
    logic [31:0]                 word_sel;

    assign accept      = (state_reg == S_IDLE) && ld_valid;
    assign timeout_hit = (timeout_cnt_reg == TIMEOUT_LAST);

    // Classify the incoming request: misaligned for its size, or reserved funct3
    always_comb begin
        bad_req = 1'b0;
        case (ld_funct3)
            F3_LB, F3_LBU: bad_req = 1'b0;
            F3_LH, F3_LHU: bad_req = ld_addr[0];
            F3_LW, F3_LWU: bad_req = |ld_addr[1:0];
            F3_LD:         bad_req = |ld_addr[2:0];
            default:       bad_req = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (ld_valid) begin
                    state_next = bad_req ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = S_WB;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WB:    state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request context, response capture and the WAIT timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg        <= '0;
            funct3_reg      <= '0;
            rd_reg          <= '0;
            data_reg        <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= ld_addr;
                funct3_reg <= ld_funct3;
                rd_reg     <= ld_rd;
            end
            if ((state_reg == S_REQ) && mem_req_ready) begin
                timeout_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                if (mem_rsp_valid) begin
                    data_reg <= mem_rdata;
                end else begin
                    timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                end
            end
        end
    end

    // Split the captured doubleword into naturally aligned lanes
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
            assign byte_lane[gi] = data_reg[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < NUM_HALFS; gi++) begin : g_half_lane
            assign half_lane[gi] = data_reg[gi*16 +: 16];
        end
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_lane
            assign word_lane[gi] = data_reg[gi*32 +: 32];
        end
    endgenerate

    // Alignment is already guaranteed, so the low address bits pick the lane
    assign byte_sel = byte_lane[addr_reg[2:0]];
    assign half_sel = half_lane[addr_reg[2:1]];
    assign word_sel = word_lane[addr_reg[2]];

    // Sign- or zero-extend the selected field to full width
    always_comb begin
        ext_data = data_reg;
        case (funct3_reg[1:0])
            2'b00: ext_data = {{(CPU_WIDTH-8){byte_sel[7] & ~funct3_reg[2]}}, byte_sel};
            2'b01: ext_data = {{(CPU_WIDTH-16){half_sel[15] & ~funct3_reg[2]}}, half_sel};
            2'b10: ext_data = {{(CPU_WIDTH-32){word_sel[31] & ~funct3_reg[2]}}, word_sel};
            default: ext_data = data_reg;
        endcase
    end

    // Outputs decoded from state; data buses are held at zero when idle
    always_comb begin
        ld_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_raddr     = '0;
        reg_wen       = 1'b0;
        reg_waddr     = '0;
        reg_wdata     = '0;
        ld_done       = 1'b0;
        ld_err        = 1'b0;
        case (state_reg)
            S_IDLE: ld_ready = 1'b1;
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_raddr     = {addr_reg[CPU_WIDTH-1:3], 3'b000};
            end
            S_WB: begin
                reg_wen   = (rd_reg != '0);
                reg_waddr = rd_reg;
                reg_wdata = ext_data;
                ld_done   = 1'b1;
            end
            S_ERR: begin
                ld_done = 1'b1;
                ld_err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed scenarios followed by randomized loads, each checked
// against a reference model computed from the load semantics.
module tb_load_unit;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [4:0]  ld_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_raddr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic        ld_done;
    logic        ld_err;

    int checks = 0;
    int errors = 0;

    load_unit #(
        .CPU_WIDTH(64),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr(ld_addr),
        .ld_funct3(ld_funct3),
        .ld_rd(ld_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_raddr(mem_raddr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .reg_wen(reg_wen),
        .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata),
        .ld_done(ld_done),
        .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a funct3
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    // Reserved encoding or address not a multiple of the access size
    function automatic bit ref_bad(input logic [63:0] addr, input logic [2:0] f3);
        if (f3 == 3'd7) return 1'b1;
        return (addr % 64'(ref_size(f3))) != 64'd0;
    endfunction

    // Shift the addressed bytes down, truncate to size, then extend
    function automatic logic [63:0] ref_ext(input logic [63:0] addr, input logic [2:0] f3,
                                            input logic [63:0] rdata);
        logic [63:0] v;
        int sz;
        int off;
        sz  = ref_size(f3);
        off = int'(addr % 64'd8);
        v   = rdata >> (8 * off);
        if (sz < 8) begin
            v = v & ((64'd1 << (8 * sz)) - 64'd1);
            if (f3 < 3'd4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
        end
        return v;
    endfunction

    // One complete load with the given handshake delays, checked cycle by cycle
    task automatic do_load(input logic [63:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] rdata, input int rdy_dly, input int rsp_dly);
        logic        exp_bad;
        logic [63:0] exp_data;
        int          cyc;
        exp_bad  = ref_bad(addr, f3);
        exp_data = ref_ext(addr, f3, rdata);
        @(negedge clk);
        chk("ready_idle", ld_ready, 1'b1);
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_addr = {$urandom, $urandom}; ld_funct3 = 3'($urandom); ld_rd = 5'($urandom);
        cyc = 1;
        if (exp_bad) begin
            @(negedge clk);
            chk("err_done", ld_done, 1'b1);
            chk("err_flag", ld_err, 1'b1);
            chk("err_wen", reg_wen, 1'b0);
            chk("err_noreq", mem_req_valid, 1'b0);
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                chk("req_valid_hold", mem_req_valid, 1'b1);
                chk("req_addr_hold", mem_raddr, {addr[63:3], 3'b000});
                @(posedge clk); #1;
                cyc++;
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            chk("req_valid", mem_req_valid, 1'b1);
            chk("req_addr", mem_raddr, {addr[63:3], 3'b000});
            chk("req_notready", ld_ready, 1'b0);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            cyc++;
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                chk("wait_wen", reg_wen, 1'b0);
                chk("wait_noreq", mem_req_valid, 1'b0);
                @(posedge clk); #1;
                cyc++;
            end
            mem_rsp_valid = 1'b1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
            cyc++;
            @(negedge clk);
            chk("wb_done", ld_done, 1'b1);
            chk("wb_err", ld_err, 1'b0);
            chk("wb_wen", reg_wen, rd != 5'd0);
            chk("wb_waddr", reg_waddr, rd);
            chk("wb_wdata", reg_wdata, exp_data);
            chk("wb_latency", cyc, 3 + rdy_dly + rsp_dly);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done", ld_done, 1'b0);
        chk("post_wen", reg_wen, 1'b0);
        chk("post_ready", ld_ready, 1'b1);
        $display("load f3=%0d addr=%h rd=%0d rdata=%h bad=%0d exp=%h", f3, addr, rd, rdata, exp_bad, exp_data);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f;
        int          waited;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_req", mem_req_valid, 1'b0);
        chk("rst_raddr", mem_raddr, 64'd0);
        chk("rst_done", ld_done, 1'b0);
        chk("rst_err", ld_err, 1'b0);
        chk("rst_wen", reg_wen, 1'b0);
        chk("rst_wdata", reg_wdata, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed loads
        do_load(64'h8000_0003, 3'b000, 5'd1, 64'h0000_0000_8000_0000, 0, 0);
        chk("lb_model", ref_ext(64'h8000_0003, 3'b000, 64'h8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
        do_load(64'h8000_0004, 3'b110, 5'd5, 64'h8765_4321_0000_0000, 0, 1);
        do_load(64'h8000_0004, 3'b010, 5'd5, 64'h8765_4321_0000_0000, 1, 0);
        do_load(64'h8000_0001, 3'b001, 5'd3, 64'd0, 0, 0);
        do_load(64'h8000_0000, 3'b111, 5'd3, 64'd0, 0, 0);
        do_load(64'h8000_0008, 3'b011, 5'd0, 64'h1234, 3, 0);
        do_load(64'h8000_0006, 3'b101, 5'd31, 64'hFEDC_0000_0000_0000, 0, 2);

        // Timeout: accept an LD, complete the request, never respond
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_addr = 64'h8000_0010; ld_funct3 = 3'b011; ld_rd = 5'd7;
        @(posedge clk); #1;
        ld_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        waited = 0;
        while (waited < 400) begin
            @(negedge clk);
            if (ld_done) break;
            chk("to_wen", reg_wen, 1'b0);
            @(posedge clk); #1;
            waited++;
        end
        chk("to_cycles", waited, 255);
        chk("to_err", ld_err, 1'b1);
        chk("to_done", ld_done, 1'b1);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_wen", reg_wen, 1'b0);
        chk("late_done", ld_done, 1'b0);
        chk("late_ready", ld_ready, 1'b1);
        $display("load timeout waited=%0d", waited);

        // Reset in WAIT, then a stray response, then a normal load
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_addr = 64'h8000_0020; ld_funct3 = 3'b011; ld_rd = 5'd9;
        @(posedge clk); #1;
        ld_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ld_ready, 1'b1);
        chk("arst_req", mem_req_valid, 1'b0);
        chk("arst_done", ld_done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h5555_5555;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("arst_stray_wen", reg_wen, 1'b0);
        chk("arst_stray_done", ld_done, 1'b0);
        $display("load reset_in_wait done");
        do_load(64'h8000_0028, 3'b011, 5'd9, 64'h0123_4567_89AB_CDEF, 0, 0);

        // Randomized loads; half of them forced to their natural alignment
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~(64'(ref_size(f)) - 64'd1);
            do_load(a, f, 5'($urandom), {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
